// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction icodes and architectural status codes.
package y86_pkg;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  typedef enum logic [1:0] {
    SAOK = 2'd0,
    SHLT = 2'd1,
    SADR = 2'd2,
    SINS = 2'd3
  } stat_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. Oldest entries are overwritten on overflow;
// a flush empties the stack while leaving the write pointer where it was.
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] base_count;
  logic [W-1:0]     mem [DEPTH];

  // A flush is visible in the same cycle so the instruction fetched at the
  // corrected PC already sees (and pushes/pops onto) an empty stack.
  assign base_count = flush ? '0 : count;
  assign empty      = (base_count == '0);
  assign top        = mem[ptr - PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (en) begin
      if (push) begin
        ptr   <= ptr + PTR_W'(1);
        count <= (base_count == CNT_W'(DEPTH)) ? base_count : base_count + CNT_W'(1);
      end else if (pop && !empty) begin
        ptr   <= ptr - PTR_W'(1);
        count <= base_count - CNT_W'(1);
      end else begin
        count <= base_count;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && push) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/pc_select_pred.sv
// Fetch-PC selection and next-PC prediction for the pipelined Y86-64 core,
// with an optional return-address stack for ret targets.
module pc_select_pred
  import y86_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter int                RAS_DEPTH = 8,
  parameter int                RAS_EN    = 1,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        f_icode,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  input  logic              f_stall,
  input  logic [3:0]        M_icode,
  input  logic              M_cnd,
  input  logic [ADDR_W-1:0] M_valA,
  input  logic [3:0]        W_icode,
  input  logic [ADDR_W-1:0] W_valM,
  input  logic [ADDR_W-1:0] W_ret_pred,
  input  logic [1:0]        stat,
  output logic [ADDR_W-1:0] f_pc,
  output logic [ADDR_W-1:0] f_ret_pred,
  output logic              ret_mispredict,
  output logic              jmp_mispredict,
  output logic              halted
);

  logic [ADDR_W-1:0] pred_pc;
  logic [ADDR_W-1:0] next_pred;
  logic [ADDR_W-1:0] ret_pred;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              correction;
  logic              upd_en;
  logic              is_call;
  logic              is_ret;

  assign jmp_mispredict = (M_icode == IJXX) && !M_cnd;
  assign ret_mispredict = (W_icode == IRET) && (W_valM != W_ret_pred);
  assign correction     = jmp_mispredict || ret_mispredict;

  assign is_call = (f_icode == ICALL);
  assign is_ret  = (f_icode == IRET);
  assign upd_en  = !halted && (stat == SAOK) && !f_stall;

  // The older W-stage ret correction outranks the M-stage jump correction.
  always_comb begin
    f_pc = pred_pc;
    if (ret_mispredict) begin
      f_pc = W_valM;
    end else if (jmp_mispredict) begin
      f_pc = M_valA;
    end
  end

  generate
    if (RAS_EN != 0) begin : g_ras
      ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
      ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .en    (upd_en),
        .flush (correction),
        .push  (is_call),
        .pop   (is_ret),
        .din   (f_valP),
        .top   (ras_top),
        .empty (ras_empty)
      );
    end else begin : g_no_ras
      assign ras_top   = '0;
      assign ras_empty = 1'b1;
    end
  endgenerate

  assign ret_pred   = ras_empty ? f_valP : ras_top;
  assign f_ret_pred = is_ret ? ret_pred : f_valP;

  always_comb begin
    next_pred = f_valP;
    if ((f_icode == IJXX) || is_call) begin
      next_pred = f_valC;
    end else if (is_ret) begin
      next_pred = ret_pred;
    end
  end

  // Once a non-AOK status has been seen, the prediction stays frozen until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_pc <= RESET_PC;
      halted  <= 1'b0;
    end else if (halted || (stat != SAOK)) begin
      halted  <= 1'b1;
    end else if (!f_stall) begin
      pred_pc <= next_pred;
    end
  end

endmodule

// File: tb/tb_pc_select_pred.sv
// Self-checking bench for pc_select_pred: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_pc_select_pred;

  localparam logic [63:0] RST_PC = 64'h100;
  localparam int          DEPTH  = 8;

  logic        clk;
  logic        rst;
  logic [3:0]  f_icode;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic        f_stall;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic [63:0] W_ret_pred;
  logic [1:0]  stat;
  logic [63:0] f_pc;
  logic [63:0] f_ret_pred;
  logic        ret_mispredict;
  logic        jmp_mispredict;
  logic        halted;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: predicted PC, halt flag and RAS as a plain queue.
  logic [63:0] m_pred;
  logic        m_halted;
  logic        m_valid = 1'b0;
  logic [63:0] ras_q[$];

  pc_select_pred #(
    .ADDR_W    (64),
    .RAS_DEPTH (DEPTH),
    .RAS_EN    (1),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .f_icode        (f_icode),
    .f_valC         (f_valC),
    .f_valP         (f_valP),
    .f_stall        (f_stall),
    .M_icode        (M_icode),
    .M_cnd          (M_cnd),
    .M_valA         (M_valA),
    .W_icode        (W_icode),
    .W_valM         (W_valM),
    .W_ret_pred     (W_ret_pred),
    .stat           (stat),
    .f_pc           (f_pc),
    .f_ret_pred     (f_ret_pred),
    .ret_mispredict (ret_mispredict),
    .jmp_mispredict (jmp_mispredict),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst        = 1'b0;
    f_icode    = 4'h1;
    f_valC     = 64'h0;
    f_valP     = 64'h0;
    f_stall    = 1'b0;
    M_icode    = 4'h1;
    M_cnd      = 1'b1;
    M_valA     = 64'h0;
    W_icode    = 4'h1;
    W_valM     = 64'h0;
    W_ret_pred = 64'h0;
    stat       = 2'd0;
  endtask

  // Checks the combinational outputs against the model, clocks once and
  // advances the model; returns on the following falling edge.
  task automatic applyStimulus();
    logic        jm, rm;
    logic [63:0] exp_pc, rp, nxt;
    int          sz;
    #1;
    jm     = (M_icode == 4'd7) && !M_cnd;
    rm     = (W_icode == 4'd9) && (W_valM != W_ret_pred);
    sz     = (jm || rm) ? 0 : ras_q.size();
    rp     = (sz > 0) ? ras_q[$] : f_valP;
    exp_pc = rm ? W_valM : (jm ? M_valA : m_pred);
    if (m_valid) begin
      checkOutput("f_pc", f_pc, exp_pc);
      checkOutput("f_ret_pred", f_ret_pred, (f_icode == 4'd9) ? rp : f_valP);
      checkOutput("jmp_mispredict", {63'd0, jmp_mispredict}, {63'd0, jm});
      checkOutput("ret_mispredict", {63'd0, ret_mispredict}, {63'd0, rm});
      checkOutput("halted", {63'd0, halted}, {63'd0, m_halted});
    end
    @(posedge clk);
    if (rst) begin
      m_pred   = RST_PC;
      m_halted = 1'b0;
      ras_q.delete();
      m_valid  = 1'b1;
    end else if (m_halted || stat != 2'd0) begin
      m_halted = 1'b1;
    end else if (!f_stall) begin
      if (jm || rm) ras_q.delete();
      nxt = f_valP;
      if (f_icode == 4'd7 || f_icode == 4'd8) nxt = f_valC;
      else if (f_icode == 4'd9) nxt = rp;
      if (f_icode == 4'd8) begin
        ras_q.push_back(f_valP);
        if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
      end else if (f_icode == 4'd9 && ras_q.size() > 0) begin
        void'(ras_q.pop_back());
      end
      m_pred = nxt;
    end
    @(negedge clk);
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
    idle();
    f_icode = ic;
    f_valC  = vc;
    f_valP  = vp;
  endtask

  initial begin
    logic [63:0] frozen;
    idle();
    m_pred   = RST_PC;
    m_halted = 1'b0;
    rst = 1'b1;
    applyStimulus();
    applyStimulus();

    // Sequential flow straight out of reset.
    fetch(4'h1, 64'h0, 64'h101);
    #1 checkOutput("reset_fpc", f_pc, 64'h100);
    checkOutput("reset_halted", {63'd0, halted}, 64'd0);
    applyStimulus();
    fetch(4'h8, 64'h300, 64'h109);
    #1 checkOutput("seq_fpc", f_pc, 64'h101);
    applyStimulus();
    fetch(4'h9, 64'h0, 64'h301);
    #1 checkOutput("call_target", f_pc, 64'h300);
    checkOutput("ret_pred_call", f_ret_pred, 64'h109);
    applyStimulus();
    fetch(4'h1, 64'h0, 64'h10A);
    W_icode = 4'h9; W_valM = 64'h109; W_ret_pred = 64'h109;
    #1 checkOutput("ret_target", f_pc, 64'h109);
    checkOutput("ret_ok", {63'd0, ret_mispredict}, 64'd0);
    applyStimulus();

    // Not-taken jump correction flushes the RAS.
    fetch(4'h8, 64'h500, 64'h555);
    applyStimulus();
    fetch(4'h7, 64'h200, 64'h50A);
    applyStimulus();
    fetch(4'h1, 64'h0, 64'h201);
    applyStimulus();
    fetch(4'h1, 64'h0, 64'h10B);
    M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h10A;
    #1 checkOutput("jmp_fix_pc", f_pc, 64'h10A);
    checkOutput("jmp_flag", {63'd0, jmp_mispredict}, 64'd1);
    applyStimulus();
    fetch(4'h9, 64'h0, 64'h10C);
    #1 checkOutput("ras_flushed", f_ret_pred, 64'h10C);
    applyStimulus();

    // Nine nested calls overflow an eight-entry stack.
    for (int i = 0; i < 9; i++) begin
      fetch(4'h8, 64'h4000 + 64'(i) * 64'h100, 64'h3000 + 64'(i) * 64'h4);
      applyStimulus();
    end
    for (int i = 0; i < 9; i++) begin
      fetch(4'h9, 64'h0, 64'h6000 + 64'(i));
      #1 checkOutput($sformatf("nest_ret%0d", i), f_ret_pred,
                     (i < 8) ? 64'h3000 + 64'(8 - i) * 64'h4 : 64'h6008);
      applyStimulus();
    end
    fetch(4'h1, 64'h0, 64'h7001);
    W_icode = 4'h9; W_valM = 64'h7777; W_ret_pred = 64'h6008;
    #1 checkOutput("ret_fix_pc", f_pc, 64'h7777);
    checkOutput("ret_flag", {63'd0, ret_mispredict}, 64'd1);
    applyStimulus();

    // Stalled call: three held cycles, then exactly one push.
    frozen = m_pred;
    for (int i = 0; i < 3; i++) begin
      fetch(4'h8, 64'h800, 64'h808);
      f_stall = 1'b1;
      #1 checkOutput("stall_hold", f_pc, frozen);
      applyStimulus();
    end
    fetch(4'h8, 64'h800, 64'h808);
    applyStimulus();
    fetch(4'h9, 64'h0, 64'h801);
    #1 checkOutput("stall_push", f_ret_pred, 64'h808);
    applyStimulus();
    fetch(4'h9, 64'h0, 64'h901);
    #1 checkOutput("stall_one_push", f_ret_pred, 64'h901);
    applyStimulus();

    // Non-AOK status freezes everything until reset.
    fetch(4'h1, 64'h0, 64'hA00);
    stat = 2'b01;
    applyStimulus();
    frozen = m_pred;
    for (int i = 0; i < 10; i++) begin
      fetch(4'h8, 64'hB00 + 64'(i), 64'hC00 + 64'(i));
      #1 checkOutput("halt_freeze", f_pc, frozen);
      checkOutput("halt_sticky", {63'd0, halted}, 64'd1);
      applyStimulus();
    end
    idle();
    rst = 1'b1;
    applyStimulus();
    idle();
    #1 checkOutput("post_rst_pc", f_pc, RST_PC);
    checkOutput("post_rst_halted", {63'd0, halted}, 64'd0);
    applyStimulus();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      idle();
      r = $urandom_range(0, 9);
      if (r <= 2)      f_icode = 4'h8;
      else if (r <= 5) f_icode = 4'h9;
      else if (r == 6) f_icode = 4'h7;
      else             f_icode = 4'($urandom_range(0, 15));
      f_valC  = {$urandom, $urandom};
      f_valP  = {$urandom, $urandom};
      f_stall = ($urandom_range(0, 9) == 0);
      M_icode = ($urandom_range(0, 5) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
      M_cnd   = 1'($urandom_range(0, 1));
      M_valA  = {$urandom, $urandom};
      W_icode = ($urandom_range(0, 4) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
      W_valM  = {$urandom, $urandom};
      W_ret_pred = ($urandom_range(0, 1) == 0) ? W_valM : {$urandom, $urandom};
      stat    = ($urandom_range(0, 149) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      rst     = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
